// File: rtl/sr_drv_pkg.sv
// sr_drv_pkg: shared FSM state encoding and constant helpers for the SR
// latch pulse driver.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    GAP
  } sr_state_e;

  // Used at elaboration time to size the shared PULSE/GAP timer.
  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// sr_drv_timer: loadable down-counter. done flags the final cycle
// (count==1), so a load of N keeps the owning state alive for N cycles.
module sr_drv_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load on state entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: sequences s/r/en for a gated SR latch
// (setup -> enable pulse -> hold -> dead gap) and mirrors the stored value.
// Optional macro SR_PULSE_DRIVER_READBACK_EN: check q_fb/qbar_fb during HOLD
// and flag err alongside ack when the latch did not take the value.
module sr_pulse_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_set,
  input  logic req_clr,
  input  logic q_fb,
  input  logic qbar_fb,
  output logic s,
  output logic r,
  output logic en,
  output logic busy,
  output logic ack,
  output logic err,
  output logic state_q
);

  localparam int TW = $clog2(max(PULSE_W, GAP_W) + 1);

  sr_state_e     state, nxt_state;
  logic          tgt, nxt_tgt;
  logic          nxt_s, nxt_r, nxt_en, nxt_ack, nxt_err, nxt_sq;
  logic          tmr_load, tmr_done, fin;
  logic [TW-1:0] tmr_val;
  logic          fin_err, fin_q;

  sr_drv_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

`ifdef SR_PULSE_DRIVER_READBACK_EN
  logic rb_bad, rb_q, fb_bad;

  assign fb_bad = (q_fb != tgt) || (qbar_fb != ~tgt);

  // Capture readback at the end of HOLD; reported when the op completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_bad <= 1'b0;
      rb_q   <= 1'b0;
    end else if (state == HOLD) begin
      rb_bad <= fb_bad;
      rb_q   <= q_fb;
    end
  end

  // With no gap, completion happens straight out of HOLD: use live readback.
  assign fin_err = (state == HOLD) ? fb_bad : rb_bad;
  assign fin_q   = fin_err ? ((state == HOLD) ? q_fb : rb_q) : tgt;
`else
  logic unused_fb;
  assign unused_fb = q_fb ^ qbar_fb;
  assign fin_err   = 1'b0;
  assign fin_q     = tgt;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    nxt_state = state;
    nxt_tgt   = tgt;
    nxt_ack   = 1'b0;
    nxt_err   = 1'b0;
    nxt_sq    = state_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (req_set && req_clr) begin
          nxt_err = 1'b1;
        end else if (req_set || req_clr) begin
          if (req_set == state_q) begin
            nxt_ack = 1'b1;
          end else begin
            nxt_tgt   = req_set;
            nxt_state = SETUP;
          end
        end
      end
      SETUP: begin
        nxt_state = PULSE;
        tmr_load  = 1'b1;
        tmr_val   = TW'(PULSE_W);
      end
      PULSE: if (tmr_done) nxt_state = HOLD;
      HOLD: begin
        if (GAP_W == 0) begin
          fin = 1'b1;
        end else begin
          nxt_state = GAP;
          tmr_load  = 1'b1;
          tmr_val   = TW'(GAP_W);
        end
      end
      GAP:     if (tmr_done) fin = 1'b1;
      default: nxt_state = IDLE;
    endcase
    if (fin) begin
      nxt_state = IDLE;
      nxt_ack   = 1'b1;
      nxt_err   = fin_err;
      nxt_sq    = fin_q;
    end
    // tgt only moves in IDLE, so s/r are stable for the whole enable pulse
    // and can never both be high.
    nxt_s  = (nxt_state inside {SETUP, PULSE, HOLD}) &&  nxt_tgt;
    nxt_r  = (nxt_state inside {SETUP, PULSE, HOLD}) && !nxt_tgt;
    nxt_en = (nxt_state == PULSE);
  end

  // State and registered outputs; reset drops the latch drive immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tgt     <= 1'b0;
      s       <= 1'b0;
      r       <= 1'b0;
      en      <= 1'b0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      state_q <= 1'b0;
    end else begin
      state   <= nxt_state;
      tgt     <= nxt_tgt;
      s       <= nxt_s;
      r       <= nxt_r;
      en      <= nxt_en;
      busy    <= (nxt_state != IDLE);
      ack     <= nxt_ack;
      err     <= nxt_err;
      state_q <= nxt_sq;
    end
  end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver: directed scenarios plus random requests, checked every
// cycle against a timeline model built from the request-to-output offsets.
module tb_sr_pulse_driver;

  localparam int PW  = 2;
  localparam int GW  = 1;
  localparam int LAT = 3 + PW + GW;
`ifdef SR_PULSE_DRIVER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic req_set = 1'b0, req_clr = 1'b0;
  logic q_fb, qbar_fb;
  logic s, r, en, busy, ack, err, state_q;

  int total = 0, bad = 0;

  // model state
  int e = 0;
  bit op_act = 0;
  int op_k = 0;
  bit op_val = 0, op_fb = 0, mirror = 0;
  bit fb_force = 0;
  logic q_lat = 1'b0;

  always #5 clk = ~clk;

  sr_pulse_driver #(.PULSE_W(PW), .GAP_W(GW)) dut (
    .clk(clk), .rst(rst), .req_set(req_set), .req_clr(req_clr),
    .q_fb(q_fb), .qbar_fb(qbar_fb), .s(s), .r(r), .en(en), .busy(busy),
    .ack(ack), .err(err), .state_q(state_q)
  );

  // Behavioural stand-in for the physical latch feeding the readback pins.
  always @(posedge clk)
    if (en) q_lat <= s ? 1'b1 : (r ? 1'b0 : q_lat);
  assign q_fb    = fb_force ? 1'b0 : q_lat;
  assign qbar_fb = ~q_fb;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, e);
    end
  endtask

  // Decide what edge e does with the sampled request, then check cycle e+1.
  task automatic model_edge(input bit rs, input bit rc);
    bit idle, red_ack, rej_err, fin, fin_err;
    int d;
    red_ack = 0; rej_err = 0; fin_err = 0;
    idle = !op_act || (e >= op_k + LAT);
    if (idle && (rs || rc)) begin
      if (rs && rc)          rej_err = 1;
      else if (rs == mirror) red_ack = 1;
      else begin
        op_act = 1; op_k = e; op_val = rs;
        op_fb  = fb_force ? 1'b0 : rs;
      end
    end
    d   = e + 1 - op_k;
    fin = op_act && (d == LAT);
    if (fin) begin
      mirror  = RB ? op_fb : op_val;
      fin_err = RB && (op_fb != op_val);
    end
    chk("s",       s,       int'(op_act &&  op_val && d >= 1 && d <= 2 + PW));
    chk("r",       r,       int'(op_act && !op_val && d >= 1 && d <= 2 + PW));
    chk("en",      en,      int'(op_act && d >= 2 && d <= 1 + PW));
    chk("busy",    busy,    int'(op_act && d >= 1 && d <= LAT - 1));
    chk("ack",     ack,     int'(fin || red_ack));
    chk("err",     err,     int'(rej_err || fin_err));
    chk("state_q", state_q, int'(mirror));
  endtask

  task automatic step(input bit rs, input bit rc);
    @(negedge clk);
    req_set = rs; req_clr = rc;
    @(posedge clk);
    #1;
    model_edge(rs, rc);
    e++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  // Async reset asserted mid-cycle: drive must vanish before the next edge.
  task automatic reset_mid();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_s", s, 0);  chk("rst_r", r, 0);  chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);  chk("rst_ack", ack, 0);
    @(negedge clk);
    rst = 1'b0;
    op_act = 0; mirror = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("init_s", s, 0);       chk("init_r", r, 0);     chk("init_en", en, 0);
    chk("init_busy", busy, 0); chk("init_ack", ack, 0); chk("init_err", err, 0);
    chk("init_sq", state_q, 0);
    @(negedge clk);
    rst = 1'b0;

    // basic set pulse
    step(1, 0); idle_n(7);
    // clear back to 0, then set with a clear arriving mid-operation, then a
    // clear accepted in the ack cycle
    step(0, 1); idle_n(7);
    step(1, 0); idle_n(2); step(0, 1); idle_n(2); step(0, 1); idle_n(7);
    // simultaneous requests rejected
    step(1, 1); idle_n(10);
    // redundant request (mirror is 0)
    step(0, 1); idle_n(3);
    // reset while in PULSE, then a normal op afterwards
    step(1, 0); idle_n(2);
    reset_mid();
    step(1, 0); idle_n(7);
    step(0, 1); idle_n(7);
    // readback stuck at 0 during a set
    fb_force = 1;
    step(1, 0); idle_n(7);
    fb_force = 0;
    idle_n(2);

    // random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    idle_n(LAT + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
